mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
Iterative RISC-V M-extension multiply/divide unit for the OTTER multicycle core. It sits beside the ALU: it is fed from the same srcA/srcB operand muxes, and its RESULT goes to the same register-file writeback mux. The control FSM pulses START, waits in an execute-wait state until DONE, then writes RESULT back. It is a radix-2 design, one bit per clock, with no combinational multiplier or divider array.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported and verified.

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE or DONE state
MDU_FUN  input  3  instruction funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
srcA  input  32  rs1 operand (multiplicand / dividend)
srcB  input  32  rs2 operand (multiplier / divisor)
BUSY  output  1  high while an operation is in flight (CALC or FIX)
DONE  output  1  one-cycle pulse; RESULT valid from this cycle
RESULT  output  32  result register; held until the next accepted START

Behaviour:
- Reset is asynchronous and active-low. One clock, CLK. While RST_N is low: state=IDLE, BUSY=0, DONE=0, RESULT=0, all internal registers 0.
- Reset mid-operation aborts the operation immediately. No DONE is issued for the aborted operation.
- States and transitions:
  - IDLE -> CALC on START.
  - IDLE -> FIX on START when a special case applies (see below).
  - CALC -> FIX after 32 iterations.
  - FIX -> DONE.
  - DONE -> IDLE, or DONE -> CALC/FIX if START is high in DONE. This allows back-to-back operations.
- Accept: START=1 in cycle T (IDLE or DONE state) latches srcA, srcB and MDU_FUN. Operands may change after T.
- START in CALC or FIX is ignored; there is no queueing.
- Signedness:
  - srcA is signed for MULH, MULHSU, DIV, REM.
  - srcB is signed for MULH, DIV, REM.
  - Otherwise operands are unsigned.
  - Magnitudes are taken at accept; the result sign is recorded.
- Multiply: shift-add on magnitudes into a 64-bit product, one multiplier bit per CALC cycle.
  - FIX applies two's-complement negation of the 64-bit product if the result sign is negative.
  - RESULT = product[31:0] for MUL, product[63:32] for the others.
- Divide: restoring division on magnitudes, one quotient bit per CALC cycle.
  - FIX negates the quotient if the operand signs differ (DIV).
  - FIX negates the remainder if the dividend is negative (REM).
- Latency, normal case: CALC occupies T+1..T+32, FIX is T+33, DONE pulse at T+34. BUSY=1 for T+1..T+33.
- Special cases (no CALC; FIX at T+1, DONE at T+2):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the latched dividend.
  - Signed overflow, srcA=0x80000000 and srcB=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- RESULT updates only on the FIX->DONE edge. It is stable from the DONE cycle until the next operation's DONE.
- DONE is high exactly one cycle per accepted operation. DONE and BUSY are never high together.
- Full 32-bit wrap-around on MUL. No exceptions or flags are raised.

Optional Feature:
MDU_FAST_ZERO_EN
- Defined: a MUL/MULH/MULHSU/MULHU accept with srcA==0 or srcB==0 skips CALC. FIX is at T+1, DONE at T+2, RESULT=0. Divide timing is unchanged.
- Undefined: zero-operand multiplies take the full 34-cycle path and still produce 0. No extra comparators are built.

Test Plan:
- MUL srcA=7, srcB=0xFFFFFFFA (-6): RESULT=0xFFFFFFD6 with DONE at T+34. BUSY high for exactly 33 cycles.
- MULH 0x80000000 x 0x80000000: RESULT=0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF: RESULT=0xFFFFFFFF. MULHU same operands: RESULT=0xFFFFFFFE.
- DIV -7/2: RESULT=0xFFFFFFFD. REM -7/2: RESULT=0xFFFFFFFF. DIVU 100/7: RESULT=14. REMU 100/7: RESULT=2.
- DIVU 100/0: RESULT=0xFFFFFFFF. REMU 100/0: RESULT=0x64. DIV 0x80000000/0xFFFFFFFF: RESULT=0x80000000. REM same operands: RESULT=0. All four give DONE at T+2.
- Back-to-back and ignored START:
  - START held high in the DONE cycle launches the next op with no IDLE gap.
  - START pulses during CALC change nothing.
  - Changing srcA/srcB after accept does not alter RESULT.
- Reset mid-op: drop RST_N at T+10 of a DIV. BUSY, DONE and RESULT read 0 asynchronously, and no DONE appears afterwards. A new START after release completes correctly.
- With MDU_FAST_ZERO_EN: MUL 0 x 0x12345678 gives RESULT=0 at T+2.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the OTTER control path and the iterative
// multiply/divide unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             START;
  logic [2:0]       MDU_FUN;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;

  modport master (
    output START, MDU_FUN, srcA, srcB,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, MDU_FUN, srcA, srcB,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/mdu_iter.sv
// Radix-2 iterative RV32M multiply/divide unit (one bit per clock, 34-cycle op).
// Optional macro MDU_FAST_ZERO_EN: multiplies with a zero operand finish in 2 cycles.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input logic         CLK,
  input logic         RST_N,
  mdu_iter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           fun_q, fun_d;
  logic [WIDTH-1:0]     op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic        accept_s;
  logic        is_div_s;
  logic        a_sgn_s, b_sgn_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic        div_zero_s, ovf_s, fast_zero_s, neg_in_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_shift_s, div_diff_s;
  logic        div_ge_s;
  logic [63:0] div_next_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, fix_s;

  // Operand decode at accept: signedness, magnitudes, special cases.
  always_comb begin
    is_div_s = bus.MDU_FUN[2];
    a_sgn_s  = 1'b0;
    b_sgn_s  = 1'b0;
    case (bus.MDU_FUN)
      3'd1, 3'd4, 3'd6: begin
        a_sgn_s = bus.srcA[31];
        b_sgn_s = bus.srcB[31];
      end
      3'd2: begin
        a_sgn_s = bus.srcA[31];
        b_sgn_s = 1'b0;
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
    a_mag_s    = a_sgn_s ? (~bus.srcA + 32'd1) : bus.srcA;
    b_mag_s    = b_sgn_s ? (~bus.srcB + 32'd1) : bus.srcB;
    div_zero_s = is_div_s & (bus.srcB == 32'd0);
    ovf_s      = is_div_s & ~bus.MDU_FUN[0] & (bus.srcA == 32'h8000_0000) &
                 (bus.srcB == 32'hFFFF_FFFF);
`ifdef MDU_FAST_ZERO_EN
    fast_zero_s = ~is_div_s & ((bus.srcA == 32'd0) | (bus.srcB == 32'd0));
`else
    fast_zero_s = 1'b0;
`endif
    // Remainder takes the dividend's sign; everything else the product of signs.
    if (is_div_s && bus.MDU_FUN[1]) begin
      neg_in_s = a_sgn_s;
    end else begin
      neg_in_s = a_sgn_s ^ b_sgn_s;
    end
  end

  // One shift-add / restore-subtract step and the final sign fix-up.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, op_q} : 33'd0);
    mul_next_s  = {mul_sum_s, acc_q[31:1]};
    div_shift_s = acc_q[63:31];
    div_diff_s  = div_shift_s - {1'b0, op_q};
    div_ge_s    = (div_shift_s >= {1'b0, op_q});
    div_next_s  = {(div_ge_s ? div_diff_s[31:0] : div_shift_s[31:0]), acc_q[30:0], div_ge_s};
    prod_s      = neg_q ? (~acc_q + 64'd1) : acc_q;
    quot_s      = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_s       = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    case (fun_q)
      3'd0:             fix_s = prod_s[31:0];
      3'd1, 3'd2, 3'd3: fix_s = prod_s[63:32];
      3'd4, 3'd5:       fix_s = quot_s;
      3'd6, 3'd7:       fix_s = rem_s;
      default:          fix_s = 32'd0;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    fun_d    = fun_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    accept_s = bus.START & ((state_q == S_IDLE) | (state_q == S_DONE));
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          fun_d = bus.MDU_FUN;
          cnt_d = 5'd0;
          // Special cases preload acc so FIX selects the right half unmodified.
          if (div_zero_s) begin
            acc_d   = {bus.srcA, 32'hFFFF_FFFF};
            op_d    = 32'd0;
            neg_d   = 1'b0;
            state_d = S_FIX;
          end else if (ovf_s) begin
            acc_d   = {32'd0, 32'h8000_0000};
            op_d    = 32'd0;
            neg_d   = 1'b0;
            state_d = S_FIX;
          end else if (fast_zero_s) begin
            acc_d   = 64'd0;
            op_d    = 32'd0;
            neg_d   = 1'b0;
            state_d = S_FIX;
          end else if (is_div_s) begin
            acc_d   = {32'd0, a_mag_s};
            op_d    = b_mag_s;
            neg_d   = neg_in_s;
            state_d = S_CALC;
          end else begin
            acc_d   = {32'd0, b_mag_s};
            op_d    = a_mag_s;
            neg_d   = neg_in_s;
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = fun_q[2] ? div_next_s : mul_next_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        result_d = fix_s;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CALC) | (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State register with asynchronous abort.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      fun_q    <= 3'd0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= 5'd0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      fun_q    <= fun_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: results, latency, busy window, back-to-back,
// ignored START, operand stability and asynchronous abort.
module tb_mdu_iter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the request.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.START   = 1'b1;
    bus.MDU_FUN = f;
    bus.srcA    = a;
    bus.srcB    = b;
    @(posedge clk);
  endtask

  // Returns at the negedge inside the DONE cycle (or after the cycle budget).
  task automatic wait_done(input string tag, input int lat, input logic [31:0] exp, input bit poke);
    int k       = 0;
    int busy_n  = 0;
    int overlap = 0;
    bit seen    = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.START   = 1'b0;
        bus.srcA    = $urandom;
        bus.srcB    = $urandom;
        bus.MDU_FUN = 3'($urandom_range(7, 0));
      end
      if (poke && k == 5) begin
        bus.START   = 1'b1;
        bus.srcA    = 32'd3;
        bus.srcB    = 32'd5;
        bus.MDU_FUN = 3'd0;
      end
      if (poke && k == 6) bus.START = 1'b0;
      if (bus.BUSY) busy_n++;
      if (bus.BUSY && bus.DONE) overlap++;
      if (bus.DONE) seen = 1'b1;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(lat - 1));
    check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, " result"}, bus.RESULT, exp);
  endtask

  initial begin
    int done_after_reset;
    bus.START   = 1'b0;
    bus.MDU_FUN = 3'd0;
    bus.srcA    = 32'd0;
    bus.srcB    = 32'd0;

    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.BUSY), 32'd0);
    check("reset done", 32'(bus.DONE), 32'd0);
    check("reset result", bus.RESULT, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'd7, 32'hFFFF_FFFA);
    wait_done("mul 7*-6", 34, 32'hFFFF_FFD6, 1'b0);
    @(negedge clk);
    check("done one pulse", 32'(bus.DONE), 32'd0);
    check("result held", bus.RESULT, 32'hFFFF_FFD6);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done("mulh min*min", 34, 32'h4000_0000, 1'b1);
    @(negedge clk);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhsu", 34, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu", 34, 32'hFFFF_FFFE, 1'b1);
    @(negedge clk);

    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2", 34, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    wait_done("rem -7/2", 34, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    wait_done("divu 100/7", 34, 32'd14, 1'b1);
    // Remaining requests are raised inside the DONE cycle of the previous one.
    issue(3'd7, 32'd100, 32'd7);
    wait_done("remu 100/7 b2b", 34, 32'd2, 1'b0);
    issue(3'd5, 32'd100, 32'd0);
    wait_done("divu by zero", 2, 32'hFFFF_FFFF, 1'b0);
    issue(3'd7, 32'd100, 32'd0);
    wait_done("remu by zero", 2, 32'h0000_0064, 1'b0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div overflow", 2, 32'h8000_0000, 1'b0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("rem overflow", 2, 32'd0, 1'b0);
    issue(3'd0, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul wrap", 34, 32'd0, 1'b0);
    issue(3'd3, 32'h0001_0000, 32'h0001_0000);
    wait_done("mulhu 2^32", 34, 32'd1, 1'b0);
`ifdef MDU_FAST_ZERO_EN
    issue(3'd0, 32'd0, 32'h1234_5678);
    wait_done("mul zero fast", 2, 32'd0, 1'b0);
`else
    issue(3'd0, 32'd0, 32'h1234_5678);
    wait_done("mul zero", 34, 32'd0, 1'b0);
`endif
    @(negedge clk);

    // Abort a divide at T+10 with an asynchronous reset.
    issue(3'd4, 32'd1000, 32'd3);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) bus.START = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.BUSY), 32'd0);
    check("abort done", 32'(bus.DONE), 32'd0);
    check("abort result", bus.RESULT, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_after_reset = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.DONE) done_after_reset++;
    end
    check("no done after abort", 32'(done_after_reset), 32'd0);
    issue(3'd5, 32'd100, 32'd7);
    wait_done("divu after reset", 34, 32'd14, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
